// File: rtl/square_seq.sv
// square_seq: shift-add squarer rebuilding n = root*root (+ rem when SQUARE_SEQ_REMAINDER_EN is defined)
module square_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   root,
`ifdef SQUARE_SEQ_REMAINDER_EN
    input  logic [WIDTH:0]     rem,
    output logic               rem_err,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] n
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_d;
    logic [2*WIDTH-1:0] a, acc, acc_add;
    logic [WIDTH-1:0] b;
    logic [CW-1:0] cnt;
    logic last, accept;
    assign last = cnt == CW'(WIDTH - 1);
    assign accept = state == IDLE && in_valid;
    assign acc_add = b[0] ? acc + a : acc;
    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_d;
    // next-state logic: no IDLE bypass, a finished result waits in DONE for out_ready
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = in_valid ? CALC : IDLE;
            CALC:    state_d = last ? DONE : CALC;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    // handshake outputs; in_ready is suppressed while reset is asserted
    always_comb begin
        in_ready = state == IDLE && !rst;
        out_valid = state == DONE;
    end
    // datapath: capture operands on accept, one shift-add step per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a <= '0;
            b <= '0;
            acc <= '0;
            cnt <= '0;
            n <= '0;
        end else if (accept) begin
            a <= {{WIDTH{1'b0}}, root};
            b <= root;
            cnt <= '0;
`ifdef SQUARE_SEQ_REMAINDER_EN
            acc <= (2*WIDTH)'(rem);
`else
            acc <= '0;
`endif
        end else if (state == CALC) begin
            acc <= acc_add;
            a <= a << 1;
            b <= b >> 1;
            cnt <= cnt + 1'b1;
            if (last) n <= acc_add;
        end
    end
`ifdef SQUARE_SEQ_REMAINDER_EN
    // remainder sanity flag: a valid sqrt remainder never exceeds 2*root
    always_ff @(posedge clk) begin
        if (rst) rem_err <= 1'b0;
        else if (accept) rem_err <= rem > {root, 1'b0};
    end
`endif
endmodule

// File: tb/tb_square_seq.sv
// tb_square_seq: directed self-checking bench for square_seq (WIDTH=8, either SQUARE_SEQ_REMAINDER_EN setting)
module tb_square_seq;
    localparam int W = 8;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
    logic [W-1:0] root = 0;
    logic in_ready, out_valid;
    logic [2*W-1:0] n;
    int errors = 0, checks = 0;
`ifdef SQUARE_SEQ_REMAINDER_EN
    logic [W:0] rem = 0;
    logic rem_err;
`endif

    square_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .root(root),
`ifdef SQUARE_SEQ_REMAINDER_EN
        .rem(rem), .rem_err(rem_err),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .n(n)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // launch one operand (rem already driven), return latency to out_valid and in_ready after accept
    task automatic op(input logic [W-1:0] r, output int lat, output logic rdy);
        int t = 0;
        while (!in_ready && t < 30) begin
            tick();
            t++;
        end
        root = r;
        in_valid = 1;
        tick();
        in_valid = 0;
        rdy = in_ready;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic take;
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset;
        int lat;
        logic rdy;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (n !== 16'd0) begin errors++; $display("FAIL rst_n got=%0d exp=0", n); end
        rst = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
`ifdef SQUARE_SEQ_REMAINDER_EN
        rem = 11;
        op(5, lat, rdy);
        checks++; if (n !== 16'd36 || rem_err !== 1'b1) begin errors++; $display("FAIL rst_pre n=%0d err=%b exp n=36 err=1", n, rem_err); end
        rem = 0;
`else
        op(5, lat, rdy);
        checks++; if (n !== 16'd25) begin errors++; $display("FAIL rst_pre n=%0d exp=25", n); end
`endif
        rst = 1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_done_out_valid got=%b exp=0", out_valid); end
        checks++; if (n !== 16'd0) begin errors++; $display("FAIL rst_done_n got=%0d exp=0", n); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_done_in_ready got=%b exp=0", in_ready); end
`ifdef SQUARE_SEQ_REMAINDER_EN
        checks++; if (rem_err !== 1'b0) begin errors++; $display("FAIL rst_done_rem_err got=%b exp=0", rem_err); end
`endif
        tick();
        tick();
        rst = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_after_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic;
        int lat;
        logic rdy;
        op(5, lat, rdy);
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL basic_in_ready_fall got=%b exp=0", rdy); end
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (n !== 16'd25) begin errors++; $display("FAIL basic_n5 got=%0d exp=25", n); end
        take();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_handshake out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
        checks++; if (n !== 16'd25) begin errors++; $display("FAIL basic_n_hold got=%0d exp=25", n); end
        op(12, lat, rdy);
        checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency12 got=%0d exp=8", lat); end
        checks++; if (n !== 16'd144) begin errors++; $display("FAIL basic_n12 got=%0d exp=144", n); end
        take();
    endtask

    task automatic test_remainder;
        int lat;
        logic rdy;
`ifdef SQUARE_SEQ_REMAINDER_EN
        rem = 28;
        op(14, lat, rdy);
        checks++; if (n !== 16'd224 || rem_err !== 1'b0) begin errors++; $display("FAIL rem_14 n=%0d err=%b exp n=224 err=0", n, rem_err); end
        rem = 0;
`else
        op(14, lat, rdy);
        checks++; if (n !== 16'd196) begin errors++; $display("FAIL rem_14 n=%0d exp=196", n); end
`endif
        take();
    endtask

    task automatic test_boundary;
        int lat;
        logic rdy;
`ifdef SQUARE_SEQ_REMAINDER_EN
        logic [W-1:0] rt [3] = '{8'd255, 8'd255, 8'd0};
        logic [W:0] rm [3] = '{9'd510, 9'd511, 9'd0};
        logic [2*W-1:0] ex [3] = '{16'd65535, 16'd0, 16'd0};
        logic er [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            rem = rm[i];
            op(rt[i], lat, rdy);
            checks++; if (n !== ex[i] || rem_err !== er[i] || lat != 8) begin errors++; $display("FAIL bound_%0d n=%0d err=%b lat=%0d exp n=%0d err=%b lat=8", i, n, rem_err, lat, ex[i], er[i]); end
            take();
        end
        rem = 0;
`else
        logic [W-1:0] rt [2] = '{8'd255, 8'd0};
        logic [2*W-1:0] ex [2] = '{16'd65025, 16'd0};
        for (int i = 0; i < 2; i++) begin
            op(rt[i], lat, rdy);
            checks++; if (n !== ex[i] || lat != 8) begin errors++; $display("FAIL bound_%0d n=%0d lat=%0d exp n=%0d lat=8", i, n, lat, ex[i]); end
            take();
        end
`endif
    endtask

    task automatic test_back_to_back;
        int lat;
        logic rdy;
        op(7, lat, rdy);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            root = 8'(k * 37 + 1);
            tick();
            checks++; if (out_valid !== 1'b1 || n !== 16'd49 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d out_valid=%b n=%0d in_ready=%b exp 1/49/0", k, out_valid, n, in_ready); end
        end
        in_valid = 1;
        root = 9;
        take();
        in_valid = 0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || n !== 16'd49) begin errors++; $display("FAIL bp_transfer out_valid=%b in_ready=%b n=%0d exp 0/1/49", out_valid, in_ready, n); end
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_bypass in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic rdy, seen;
        root = 200;
        in_valid = 1;
        tick();
        in_valid = 0;
        out_ready = 1;
        tick();
        tick();
        rst = 1;
        tick();
        rst = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_discard out_valid_seen=%b exp=0", seen); end
        checks++; if (n !== 16'd0) begin errors++; $display("FAIL mid_n got=%0d exp=0", n); end
        out_ready = 0;
        op(3, lat, rdy);
        checks++; if (n !== 16'd9 || lat != 8) begin errors++; $display("FAIL mid_fresh n=%0d lat=%0d exp n=9 lat=8", n, lat); end
        take();
    endtask

    initial begin
        tick();
        tick();
        tick();
        test_reset();
        test_basic();
        test_remainder();
        test_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/square_seq.md
# square_seq

Sequential squarer: the inverse of the combinational square-root block. It takes an integer root and, optionally, a square-root remainder, and reconstructs the radicand `n = root*root + rem` with an iterative shift-add multiplier. It sits on the self-check path, feeding `sqroot` results back into a comparator against the original `n`, and uses valid/ready handshakes on both sides.

## Interface
- `WIDTH`, default 8: root width. The result `n` is 2*WIDTH bits wide (16 by default, matching the `sqroot` input).
- `clk`  in  1: clock; all logic updates on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  1: `root` (and `rem`) valid.
- `in_ready`  out  1: block can accept an operand; high only in IDLE.
- `root`  in  WIDTH: unsigned root.
- `rem`  in  WIDTH+1: unsigned remainder. Present only with `SQUARE_SEQ_REMAINDER_EN`.
- `out_valid`  out  1: `n` and `rem_err` valid.
- `out_ready`  in  1: consumer accepts the result.
- `n`  out  2*WIDTH: reconstructed radicand.
- `rem_err`  out  1: captured `rem > 2*root`. Present only with `SQUARE_SEQ_REMAINDER_EN`.

## Operation
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, capture operands and go to CALC.
  - CALC: 2*WIDTH-bit multiplicand A (zero-extended `root`), WIDTH-bit multiplier B (`root`), accumulator ACC, iteration counter 0..WIDTH-1.
  - DONE: present the result.
- Capture in IDLE:
  - A = `root`, B = `root`, counter = 0.
  - ACC = `rem` zero-extended when the macro is compiled in; ACC = 0 otherwise.
  - `rem_err` flag = (`rem` > 2*`root`), computed with WIDTH+1-bit unsigned compare.
- Each CALC cycle:
  - If B[0], ACC = ACC + A, truncated to 2*WIDTH bits.
  - Then A <<= 1, B >>= 1, counter++.
  - On the iteration with counter == WIDTH-1, load the `n` register from the updated ACC and go to DONE.
- DONE:
  - `out_valid=1`; `n` and `rem_err` held stable.
  - On `out_valid && out_ready`, go to IDLE.
- Arithmetic:
  - With `rem` ≤ 2*`root`, the result is exact: maximum (2^WIDTH)^2 − 1, so it never overflows.
  - With `rem` > 2*`root`, `n` = (`root`² + `rem`) mod 2^(2*WIDTH) and `rem_err=1`. The result is still delivered; it is never dropped.
- `in_valid` is ignored outside IDLE. Operands are sampled only at the accepting edge, so changes in `root`/`rem` during CALC or DONE have no effect.

## Timing
- Reset, on any edge with `rst=1` and regardless of state (including mid-CALC or in DONE):
  - State goes to IDLE.
  - `out_valid=0`, `n=0`, `rem_err=0`; ACC, A, B and counter cleared.
  - `in_ready=0` while `rst` is high; `in_ready=1` in the first cycle after `rst` falls.
  - An in-flight result is discarded and never presented.
- Latency:
  - Call the accepting edge E0 (`in_valid && in_ready`).
  - `in_ready` falls after E0.
  - `out_valid` rises after edge E0+WIDTH (8 edges by default).
- Result handshake:
  - Completes on the edge where `out_valid && out_ready`.
  - `out_valid` falls and `in_ready` rises after that edge.
  - `out_ready` may be held high permanently, giving a throughput of one result per WIDTH+2 cycles.
  - `out_ready` while `out_valid=0` has no effect.
- Simultaneous events:
  - `in_valid` in the same cycle as result acceptance is not taken; there is no IDLE bypass.
  - `rst` overrides every handshake.
- `n` changes only on entry to DONE or on reset; it keeps its last value through IDLE and CALC.

## Configuration
- `SQUARE_SEQ_REMAINDER_EN` defined:
  - `rem` and `rem_err` ports exist.
  - ACC is preloaded with `rem`; `n = root² + rem`.
  - The bench compares `n` directly against the original `sqroot` input.
- Undefined:
  - Neither port exists; ACC is preloaded with 0; `n = root²`.
  - Latency and handshake are identical.

## Test plan
- Reset: hold `rst=1` for 3 cycles in DONE with `out_ready=0` → next cycle `out_valid=0`, `n=0`, `rem_err=0`; `in_ready=1` the cycle after `rst` falls.
- Basic, WIDTH=8: `root=5`, `rem=0` → `out_valid` rises exactly 8 edges after acceptance, `n=25`; `root=12` → `n=144`.
- Remainder (macro on): `root=14`, `rem=28` → `n=224`, `rem_err=0`. Macro off, same `root` → `n=196`.
- Boundaries (macro on):
  - `root=255`, `rem=510` → `n=65535`, `rem_err=0`.
  - `root=255`, `rem=511` → `n=0` (wrap), `rem_err=1`.
  - `root=0`, `rem=0` → `n=0`.
- Backpressure: with a result pending, hold `out_ready=0` for 5 cycles while toggling `in_valid` and `root` → `out_valid` and `n` stable, `in_ready=0`. Raise `out_ready` → exactly one transfer, then `in_ready=1`.
- Reset mid-operation: assert `rst` for 1 cycle, 3 edges after accepting `root=200` → no `out_valid` ever appears for it. A fresh `root=3` then yields `n=9` with normal latency.
